tt_board_harness: RTL
=====================

Name: tt_board_harness

Overview:
Parametrised FPGA-side harness between board pins and a TinyTapeout user design (tt_um_* core) on the dev board. It replaces direct pin wiring with input synchronisers, a debounced push-button reset, a reset/enable sequencer for the core, and registered tristate control of the bidirectional uio bus. It also provides a heartbeat LED and a button-reset event counter. It sits in the top level between the board pins (with the IOBUFs in the top level) and the core, clocked by the core clock.

Parameters:
UI_WIDTH, 8, width of dedicated input bus ui_in
UIO_WIDTH, 8, width of bidirectional bus
SYNC_STAGES, 2, flops per input synchroniser (legal >= 2)
DEBOUNCE_CYCLES, 1000, consecutive stable cycles before the button state changes (legal >= 1)
RST_HOLD_CYCLES, 16, cycles dut_rst_n is held low per reset episode (legal >= 1)
HEARTBEAT_BITS, 24, heartbeat counter width; LED = MSB

Ports:
clk  in  1  core clock; all logic on rising edge
rst  in  1  asynchronous, active-high reset
pin_btn  in  1  raw reset push-button, active-high, asynchronous to clk
pin_ui  in  UI_WIDTH  raw board inputs
ui_in  out  UI_WIDTH  synchronised inputs to core
pin_uio_i  in  UIO_WIDTH  raw uio pad input from IOBUF
pin_uio_o  out  UIO_WIDTH  uio pad output to IOBUF
pin_uio_t  out  UIO_WIDTH  IOBUF tristate, 1 = high-Z
uio_out  in  UIO_WIDTH  core uio output
uio_oe  in  UIO_WIDTH  core uio output enable, 1 = drive
uio_in  out  UIO_WIDTH  uio value presented to core
dut_rst_n  out  1  core reset, active-low
dut_ena  out  1  core enable
led_heartbeat  out  1  heartbeat MSB
rst_count  out  8  button-reset episodes, saturating

Behaviour:
- Reset (rst=1, async): all synchroniser flops 0; debounced button 0; debounce counter 0; FSM=HOLD; hold counter 0; dut_rst_n=0; dut_ena=0; pin_uio_o=0; pin_uio_t=all 1; heartbeat 0; rst_count 0. ui_in and uio_in read 0.
- Synchronisers: pin_ui, pin_uio_i and pin_btn each pass through SYNC_STAGES flops. Latency = SYNC_STAGES cycles.
- Debounce:
  - Counter resets to 0 whenever the synced button equals the debounced state.
  - Otherwise the counter increments.
  - When it reaches DEBOUNCE_CYCLES-1 on a cycle where the synced button still differs, the debounced state flips on the next edge and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES produces no change.
- Sequencer FSM, registered outputs:
  - HOLD: dut_rst_n=0. Hold counter increments each cycle.
  - HOLD -> RUN on the edge where the counter equals RST_HOLD_CYCLES-1 and the debounced button is 0. dut_rst_n=1 from that edge.
  - HOLD while the debounced button is 1: counter stays at 0, so the core is held in reset for as long as the button is held.
  - RUN: debounced-button rising edge -> HOLD with the counter cleared. rst_count increments and saturates at 255.
  - dut_ena=0 in reset; it becomes 1 on the first clk edge after rst deasserts and stays 1.
  - The first release after rst occurs RST_HOLD_CYCLES edges after rst deasserts (button idle).
- uio path:
  - pin_uio_o <= uio_out and pin_uio_t <= ~uio_oe, registered. Latency 1.
  - While dut_rst_n=0, pin_uio_t is forced to all 1 on the next edge.
  - uio_in bit i is combinational: if pin_uio_t[i]=0, the registered pin_uio_o[i] (own-drive loopback, no sync latency); else the synced pin_uio_i[i].
- Heartbeat: free-running HEARTBEAT_BITS counter with wrap-around; led_heartbeat = MSB.
- Simultaneous events: a button rising edge on the same cycle as a HOLD->RUN transition keeps FSM in HOLD, clears the counter and increments rst_count.
- rst mid-operation: immediate async return to reset values. rst_count does NOT persist.

Test Plan:
- Power-up, defaults, button idle -> dut_ena=1 one edge after rst falls; dut_rst_n=1 exactly 16 edges after rst falls; pin_uio_t=8'hFF until then.
- pin_ui=8'hA5 applied mid-cycle -> ui_in=8'hA5 after 2 edges. pin_ui toggled 1 cycle only -> seen on ui_in, delayed 2.
- Button pulses of 999 cycles (DEBOUNCE_CYCLES=1000) -> no reset, rst_count=0. 1000-cycle press -> dut_rst_n low, rst_count=1; held 5000 cycles -> stays low; released -> high RST_HOLD_CYCLES edges after debounced release.
- Core RUN, uio_oe=8'h0F, uio_out=8'h3C, pin_uio_i=8'hA0 -> pin_uio_t=8'hF0, pin_uio_o=8'h3C after 1 edge; uio_in=8'hAC once synced.
- 300 button episodes -> rst_count saturates at 255. Assert rst mid-HOLD -> all outputs return to reset values asynchronously.
- HEARTBEAT_BITS=4 -> led_heartbeat toggles every 8 cycles; counter wraps 15->0.

Source files
------------

// File: rtl/tt_board_harness.sv
// tt_board_harness: board-side wrapper for a TinyTapeout core; it synchronises the inputs,
// debounces the reset button, sequences the core's reset and enable, and registers the uio tristate.
module tt_board_harness #(
  parameter int UI_WIDTH        = 8,
  parameter int UIO_WIDTH       = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int RST_HOLD_CYCLES = 16,
  parameter int HEARTBEAT_BITS  = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pin_btn,
  input  logic [UI_WIDTH-1:0]  pin_ui,
  output logic [UI_WIDTH-1:0]  ui_in,
  input  logic [UIO_WIDTH-1:0] pin_uio_i,
  output logic [UIO_WIDTH-1:0] pin_uio_o,
  output logic [UIO_WIDTH-1:0] pin_uio_t,
  input  logic [UIO_WIDTH-1:0] uio_out,
  input  logic [UIO_WIDTH-1:0] uio_oe,
  output logic [UIO_WIDTH-1:0] uio_in,
  output logic                 dut_rst_n,
  output logic                 dut_ena,
  output logic                 led_heartbeat,
  output logic [7:0]           rst_count
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(RST_HOLD_CYCLES + 1);
  typedef enum logic {HOLD, RUN} state_t;
  logic [SYNC_STAGES-1:0][UI_WIDTH-1:0]  r_ui_sync;
  logic [SYNC_STAGES-1:0][UIO_WIDTH-1:0] r_uio_sync;
  logic [SYNC_STAGES-1:0]                r_btn_sync;
  logic                                  r_btn_db;
  logic [DW-1:0]                         r_db_cnt;
  state_t                                r_state, w_state_nx;
  logic [HW-1:0]                         r_hold_cnt, w_hold_nx;
  logic                                  r_ena;
  logic [UIO_WIDTH-1:0]                  r_uio_o, r_uio_t;
  logic [HEARTBEAT_BITS-1:0]             r_hb;
  logic [7:0]                            r_rst_count;
  logic                                  w_btn_s, w_db_hit, w_rise;
  assign w_btn_s  = r_btn_sync[SYNC_STAGES-1];
  assign w_db_hit = (w_btn_s != r_btn_db) && (r_db_cnt == DW'(DEBOUNCE_CYCLES - 1));
  // A press is acted on the same edge the debounced state rises, so it wins over a pending release
  assign w_rise   = w_db_hit & w_btn_s;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ui_sync   <= '0;
      r_uio_sync  <= '0;
      r_btn_sync  <= '0;
      r_btn_db    <= 1'b0;
      r_db_cnt    <= '0;
      r_ena       <= 1'b0;
      r_uio_o     <= '0;
      r_uio_t     <= '1;
      r_hb        <= '0;
      r_rst_count <= '0;
    end else begin
      r_ui_sync   <= {r_ui_sync[SYNC_STAGES-2:0], pin_ui};
      r_uio_sync  <= {r_uio_sync[SYNC_STAGES-2:0], pin_uio_i};
      r_btn_sync  <= {r_btn_sync[SYNC_STAGES-2:0], pin_btn};
      r_db_cnt    <= (w_btn_s == r_btn_db || w_db_hit) ? '0 : r_db_cnt + 1'b1;
      r_btn_db    <= w_db_hit ? w_btn_s : r_btn_db;
      r_ena       <= 1'b1;
      r_uio_o     <= uio_out;
      r_uio_t     <= (r_state == RUN) ? ~uio_oe : '1;
      r_hb        <= r_hb + 1'b1;
      r_rst_count <= (w_rise && r_rst_count != 8'hFF) ? r_rst_count + 1'b1 : r_rst_count;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= HOLD;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_hold_cnt <= w_hold_nx;
    end
  end
  always_comb begin
    w_state_nx = r_state;
    w_hold_nx  = r_hold_cnt;
    if (w_rise) begin
      w_state_nx = HOLD;
      w_hold_nx  = '0;
    end else if (r_state == HOLD) begin
      if (r_btn_db)
        w_hold_nx = '0;
      else if (r_hold_cnt == HW'(RST_HOLD_CYCLES - 1)) begin
        w_state_nx = RUN;
        w_hold_nx  = '0;
      end else
        w_hold_nx = r_hold_cnt + 1'b1;
    end
  end
  assign ui_in         = r_ui_sync[SYNC_STAGES-1];
  assign uio_in        = (~r_uio_t & r_uio_o) | (r_uio_t & r_uio_sync[SYNC_STAGES-1]);
  assign pin_uio_o     = r_uio_o;
  assign pin_uio_t     = r_uio_t;
  assign dut_rst_n     = (r_state == RUN);
  assign dut_ena       = r_ena;
  assign led_heartbeat = r_hb[HEARTBEAT_BITS-1];
  assign rst_count     = r_rst_count;
endmodule
